operand_stack: RTL and testbench

Parametrised operand stack for the stack calculator datapath, the next generation of the fixed 4-bit stack register. It adds configurable word width and depth, an occupancy count, full/empty status, sticky overflow/underflow error flags, a DUP operation and a selectable full-stack policy. One operation is accepted per clock, and the top two entries are always visible for the ALU and the input selectors.

---
 rtl/operand_stack_pkg.sv | 42 ++++
 rtl/operand_stack.sv | 157 +++++++++++++++
 tb/tb_operand_stack.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_stack_pkg.sv
// Shared definitions for the operand stack: op codes, per-entry mux selects
// and the per-op legality helpers used by the stack decode.
package operand_stack_pkg;

    typedef enum logic [2:0] {
        STACK_OP_IDLE  = 3'b000,
        STACK_OP_PUSH  = 3'b001,
        STACK_OP_POP   = 3'b010,
        STACK_OP_SWAP  = 3'b011,
        STACK_OP_ROLL  = 3'b100,
        STACK_OP_ROLL2 = 3'b101,
        STACK_OP_DUP   = 3'b110,
        STACK_OP_CLEAR = 3'b111
    } stack_op_e;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_SHIFT_DOWN,
        SEL_SHIFT_UP,
        SEL_IN_WORD,
        SEL_ENTRY0,
        SEL_ENTRY1,
        SEL_ZERO
    } entry_sel_e;

    // Entries that must already be present for the op to be legal.
    function automatic logic [1:0] min_depth(input stack_op_e op);
        case (op)
            STACK_OP_POP,
            STACK_OP_ROLL,
            STACK_OP_DUP:   min_depth = 2'd1;
            STACK_OP_SWAP,
            STACK_OP_ROLL2: min_depth = 2'd2;
            default:        min_depth = 2'd0;
        endcase
    endfunction

    function automatic logic grows(input stack_op_e op);
        grows = (op == STACK_OP_PUSH) || (op == STACK_OP_DUP);
    endfunction

endpackage

// File: rtl/operand_stack.sv
// Parametrised operand stack: DEPTH x WIDTH register array with per-entry
// next-value mux, occupancy counter and sticky overflow/underflow flags.
module operand_stack
    import operand_stack_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEPTH           = 8,
    parameter int DISCARD_ON_FULL = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2:0]                 op,
    input  logic [WIDTH-1:0]           in_word,
    input  logic                       clr_err,
    output logic [WIDTH-1:0]           top_word,
    output logic [WIDTH-1:0]           second_word,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] DEPTH_CNT = DW'(DEPTH);
    localparam bit DISCARD = (DISCARD_ON_FULL != 0);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DW-1:0]    count;
    logic [DW-1:0]    count_nxt;
    logic             ovf_q;
    logic             unf_q;

    stack_op_e op_e;
    logic      is_full;
    logic      too_shallow;
    logic      no_room;
    logic      accept;

    // Single legality decode shared by the array, counter and flag updates.
    always_comb begin
        op_e        = stack_op_e'(op);
        is_full     = (count == DEPTH_CNT);
        too_shallow = (count < DW'(min_depth(op_e)));
        no_room     = grows(op_e) && is_full && !too_shallow;
        accept      = !too_shallow && !(no_room && !DISCARD);
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        logic [WIDTH-1:0] down_src;
        logic [WIDTH-1:0] up_src;
        logic [WIDTH-1:0] nxt;
        entry_sel_e       sel;

        if (g == 0) begin : g_first
            assign down_src = '0;
        end else begin : g_below
            assign down_src = mem[g-1];
        end

        if (g == DEPTH - 1) begin : g_last
            assign up_src = '0;
        end else begin : g_above
            assign up_src = mem[g+1];
        end

        always_comb begin
            sel = SEL_HOLD;
            if (accept) begin
                case (op_e)
                    STACK_OP_PUSH:  sel = (g == 0) ? SEL_IN_WORD : SEL_SHIFT_DOWN;
                    STACK_OP_POP:   sel = SEL_SHIFT_UP;
                    STACK_OP_SWAP:  sel = (g == 0) ? SEL_ENTRY1 :
                                          (g == 1) ? SEL_ENTRY0 : SEL_HOLD;
                    STACK_OP_ROLL:  sel = (g == 0) ? SEL_IN_WORD : SEL_HOLD;
                    // Dropping two and pushing one: entry 0 loads, the rest shift up by one.
                    STACK_OP_ROLL2: sel = (g == 0) ? SEL_IN_WORD : SEL_SHIFT_UP;
                    STACK_OP_DUP:   sel = (g == 0) ? SEL_HOLD : SEL_SHIFT_DOWN;
                    STACK_OP_CLEAR: sel = SEL_ZERO;
                    default:        sel = SEL_HOLD;
                endcase
            end
        end

        always_comb begin
            nxt = mem[g];
            case (sel)
                SEL_HOLD:       nxt = mem[g];
                SEL_SHIFT_DOWN: nxt = down_src;
                SEL_SHIFT_UP:   nxt = up_src;
                SEL_IN_WORD:    nxt = in_word;
                SEL_ENTRY0:     nxt = mem[0];
                SEL_ENTRY1:     nxt = mem[1];
                SEL_ZERO:       nxt = '0;
                default:        nxt = mem[g];
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                mem[g] <= '0;
            end else begin
                mem[g] <= nxt;
            end
        end
    end

    always_comb begin
        count_nxt = count;
        if (accept) begin
            case (op_e)
                STACK_OP_PUSH,
                STACK_OP_DUP:   if (!is_full) count_nxt = count + DW'(1);
                STACK_OP_POP,
                STACK_OP_ROLL2: count_nxt = count - DW'(1);
                STACK_OP_CLEAR: count_nxt = '0;
                default:        count_nxt = count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

    // A new error outranks clr_err in the same cycle; CLEAR outranks both.
    always_ff @(posedge clk) begin
        if (rst || op_e == STACK_OP_CLEAR) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (no_room) begin
                ovf_q <= 1'b1;
            end else if (clr_err) begin
                ovf_q <= 1'b0;
            end
            if (too_shallow) begin
                unf_q <= 1'b1;
            end else if (clr_err) begin
                unf_q <= 1'b0;
            end
        end
    end

    assign top_word    = mem[0];
    assign second_word = mem[1];
    assign depth       = count;
    assign empty       = (count == '0);
    assign full        = is_full;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

endmodule

// File: tb/tb_operand_stack.sv
// Bench for operand_stack: three configurations driven in parallel and checked
// every cycle against a queue-based model, plus hand-computed spot checks.
module tb_operand_stack;
    import operand_stack_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr_err = 1'b0;
    logic [2:0] op = STACK_OP_IDLE;
    logic [7:0] in_word = '0;
    logic       chk_en = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    logic [3:0] d0_top, d0_sec, d0_dep;
    logic       d0_empty, d0_full, d0_ovf, d0_unf;
    logic [3:0] d1_top, d1_sec, d1_dep;
    logic       d1_empty, d1_full, d1_ovf, d1_unf;
    logic [7:0] d2_top, d2_sec;
    logic [1:0] d2_dep;
    logic       d2_empty, d2_full, d2_ovf, d2_unf;

    operand_stack #(.WIDTH(4), .DEPTH(8), .DISCARD_ON_FULL(0)) dut0 (
        .clk(clk), .rst(rst), .op(op), .in_word(in_word[3:0]), .clr_err(clr_err),
        .top_word(d0_top), .second_word(d0_sec), .depth(d0_dep), .empty(d0_empty),
        .full(d0_full), .overflow(d0_ovf), .underflow(d0_unf)
    );

    operand_stack #(.WIDTH(4), .DEPTH(8), .DISCARD_ON_FULL(1)) dut1 (
        .clk(clk), .rst(rst), .op(op), .in_word(in_word[3:0]), .clr_err(clr_err),
        .top_word(d1_top), .second_word(d1_sec), .depth(d1_dep), .empty(d1_empty),
        .full(d1_full), .overflow(d1_ovf), .underflow(d1_unf)
    );

    operand_stack #(.WIDTH(8), .DEPTH(2), .DISCARD_ON_FULL(0)) dut2 (
        .clk(clk), .rst(rst), .op(op), .in_word(in_word), .clr_err(clr_err),
        .top_word(d2_top), .second_word(d2_sec), .depth(d2_dep), .empty(d2_empty),
        .full(d2_full), .overflow(d2_ovf), .underflow(d2_unf)
    );

    // ---------------- behavioural model ----------------
    localparam int P_W [3] = '{4, 4, 8};
    localparam int P_D [3] = '{8, 8, 2};
    localparam int P_DISC [3] = '{0, 1, 0};

    logic [7:0] m_ent [3][8];
    int         m_cnt [3];
    logic       m_ov [3];
    logic       m_un [3];

    task automatic model_reset(input int k);
        for (int i = 0; i < 8; i++) m_ent[k][i] = '0;
        m_cnt[k] = 0;
        m_ov[k]  = 1'b0;
        m_un[k]  = 1'b0;
    endtask

    task automatic model_step(input int k, input logic [2:0] o, input logic [7:0] w_in,
                              input logic c);
        logic [7:0] s[$];
        logic [7:0] w;
        logic [7:0] t;
        int need;
        logic ov_set;
        logic un_set;
        ov_set = 1'b0;
        un_set = 1'b0;
        w = w_in & (8'hFF >> (8 - P_W[k]));
        for (int i = 0; i < m_cnt[k]; i++) s.push_back(m_ent[k][i]);
        case (o)
            STACK_OP_POP, STACK_OP_ROLL, STACK_OP_DUP: need = 1;
            STACK_OP_SWAP, STACK_OP_ROLL2:             need = 2;
            default:                                   need = 0;
        endcase
        if (o == STACK_OP_CLEAR) begin
            s.delete();
            m_ov[k] = 1'b0;
            m_un[k] = 1'b0;
        end else begin
            if (s.size() < need) begin
                un_set = 1'b1;
            end else if ((o == STACK_OP_PUSH || o == STACK_OP_DUP) && s.size() == P_D[k]) begin
                ov_set = 1'b1;
                if (P_DISC[k] != 0) begin
                    t = (o == STACK_OP_PUSH) ? w : s[0];
                    s.push_front(t);
                    void'(s.pop_back());
                end
            end else begin
                case (o)
                    STACK_OP_PUSH: s.push_front(w);
                    STACK_OP_POP:  void'(s.pop_front());
                    STACK_OP_SWAP: begin t = s[0]; s[0] = s[1]; s[1] = t; end
                    STACK_OP_ROLL: s[0] = w;
                    STACK_OP_ROLL2: begin
                        void'(s.pop_front());
                        void'(s.pop_front());
                        s.push_front(w);
                    end
                    STACK_OP_DUP:  begin t = s[0]; s.push_front(t); end
                    default: ;
                endcase
            end
            m_ov[k] = ov_set ? 1'b1 : (c ? 1'b0 : m_ov[k]);
            m_un[k] = un_set ? 1'b1 : (c ? 1'b0 : m_un[k]);
        end
        m_cnt[k] = s.size();
        for (int i = 0; i < 8; i++) m_ent[k][i] = (i < s.size()) ? s[i] : 8'h00;
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) model_reset(k);
            else     model_step(k, op, in_word, clr_err);
        end
    end

    // ---------------- per-cycle compare ----------------
    function automatic logic [31:0] pack(input logic [7:0] tp, input logic [7:0] sc,
                                         input logic [3:0] dp, input logic e, input logic f,
                                         input logic o, input logic u);
        pack = {8'h00, tp, sc, dp, e, f, o, u};
    endfunction

    always @(negedge clk) begin
        logic [31:0] act [3];
        logic [31:0] exp_v;
        if (chk_en) begin
            act[0] = pack({4'h0, d0_top}, {4'h0, d0_sec}, d0_dep, d0_empty, d0_full, d0_ovf, d0_unf);
            act[1] = pack({4'h0, d1_top}, {4'h0, d1_sec}, d1_dep, d1_empty, d1_full, d1_ovf, d1_unf);
            act[2] = pack(d2_top, d2_sec, {2'b00, d2_dep}, d2_empty, d2_full, d2_ovf, d2_unf);
            for (int k = 0; k < 3; k++) begin
                exp_v = pack(m_ent[k][0], m_ent[k][1], 4'(m_cnt[k]), m_cnt[k] == 0,
                             m_cnt[k] == P_D[k], m_ov[k], m_un[k]);
                vectors++;
                if (act[k] !== exp_v) begin
                    miscompares++;
                    $display("FAIL cycle_dut%0d t=%0t: got %h, expected %h (top,sec,depth,e/f/o/u)",
                             k, $time, act[k], exp_v);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic lit(input string name, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic apply(input logic [2:0] o, input logic [7:0] w, input logic c);
        op      = o;
        in_word = w;
        clr_err = c;
        @(posedge clk);
        #1;
        op      = STACK_OP_IDLE;
        clr_err = 1'b0;
    endtask

    initial begin
        int r;
        logic [2:0] o;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        lit("rst_depth", int'(d0_dep), 0);
        lit("rst_empty", int'(d0_empty), 1);
        lit("rst_top", int'(d0_top), 0);

        apply(STACK_OP_PUSH, 8'd3, 1'b0);
        apply(STACK_OP_PUSH, 8'd5, 1'b0);
        lit("push_top", int'(d0_top), 5);
        lit("push_sec", int'(d0_sec), 3);
        lit("push_depth", int'(d0_dep), 2);
        apply(STACK_OP_SWAP, 8'd0, 1'b0);
        lit("swap_top", int'(d0_top), 3);
        lit("swap_sec", int'(d0_sec), 5);

        apply(STACK_OP_CLEAR, 8'd0, 1'b0);
        for (int i = 1; i <= 8; i++) apply(STACK_OP_PUSH, 8'(i), 1'b0);
        lit("full8", int'(d0_full), 1);
        lit("top8", int'(d0_top), 8);
        apply(STACK_OP_PUSH, 8'd9, 1'b0);
        lit("ovf_top", int'(d0_top), 8);
        lit("ovf_depth", int'(d0_dep), 8);
        lit("ovf_flag", int'(d0_ovf), 1);
        lit("disc_top", int'(d1_top), 9);
        lit("disc_depth", int'(d1_dep), 8);
        lit("disc_ovf", int'(d1_ovf), 1);
        lit("disc_e7", int'(dut1.mem[7]), 2);

        apply(STACK_OP_CLEAR, 8'd0, 1'b0);
        apply(STACK_OP_POP, 8'd0, 1'b0);
        lit("pop_empty_un", int'(d0_unf), 1);
        lit("pop_empty_depth", int'(d0_dep), 0);
        apply(STACK_OP_PUSH, 8'd6, 1'b0);
        apply(STACK_OP_SWAP, 8'd0, 1'b0);
        lit("swap1_depth", int'(d0_dep), 1);
        lit("swap1_top", int'(d0_top), 6);
        apply(STACK_OP_ROLL2, 8'd9, 1'b0);
        lit("roll2_1_top", int'(d0_top), 6);
        lit("roll2_1_un", int'(d0_unf), 1);
        apply(STACK_OP_CLEAR, 8'd0, 1'b0);
        lit("clear_un", int'(d0_unf), 0);
        apply(STACK_OP_POP, 8'd0, 1'b1);
        lit("clr_vs_err", int'(d0_unf), 1);
        apply(STACK_OP_IDLE, 8'd0, 1'b1);
        lit("clr_err", int'(d0_unf), 0);

        apply(STACK_OP_PUSH, 8'd7, 1'b0);
        apply(STACK_OP_PUSH, 8'd2, 1'b0);
        apply(STACK_OP_ROLL2, 8'd9, 1'b0);
        lit("roll2_depth", int'(d0_dep), 1);
        lit("roll2_top", int'(d0_top), 9);
        lit("roll2_sec", int'(d0_sec), 0);
        apply(STACK_OP_DUP, 8'd0, 1'b0);
        lit("dup_depth", int'(d0_dep), 2);
        lit("dup_top", int'(d0_top), 9);
        lit("dup_sec", int'(d0_sec), 9);
        apply(STACK_OP_ROLL, 8'd4, 1'b0);
        lit("roll_top", int'(d0_top), 4);
        lit("roll_sec", int'(d0_sec), 9);

        apply(STACK_OP_CLEAR, 8'd0, 1'b0);
        apply(STACK_OP_PUSH, 8'hA5, 1'b0);
        apply(STACK_OP_PUSH, 8'h3C, 1'b0);
        lit("d2_top", int'(d2_top), 'h3C);
        lit("d2_sec", int'(d2_sec), 'hA5);
        apply(STACK_OP_PUSH, 8'h11, 1'b0);
        lit("d2_ovf", int'(d2_ovf), 1);
        lit("d2_ovf_top", int'(d2_top), 'h3C);
        apply(STACK_OP_CLEAR, 8'd0, 1'b0);
        lit("d2_clr_depth", int'(d2_dep), 0);
        lit("d2_clr_empty", int'(d2_empty), 1);
        lit("d2_clr_top", int'(d2_top), 0);
        lit("d2_clr_ovf", int'(d2_ovf), 0);
        apply(STACK_OP_PUSH, 8'h55, 1'b0);
        rst = 1'b1;
        apply(STACK_OP_PUSH, 8'h77, 1'b0);
        rst = 1'b0;
        lit("rst_push_depth", int'(d2_dep), 0);
        lit("rst_push_top", int'(d2_top), 0);
        lit("rst_push_empty", int'(d2_empty), 1);

        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 35)      o = STACK_OP_PUSH;
            else if (r < 45) o = STACK_OP_DUP;
            else if (r < 62) o = STACK_OP_POP;
            else if (r < 70) o = STACK_OP_SWAP;
            else if (r < 78) o = STACK_OP_ROLL;
            else if (r < 86) o = STACK_OP_ROLL2;
            else if (r < 93) o = STACK_OP_IDLE;
            else if (r < 96) o = STACK_OP_CLEAR;
            else             o = 3'($urandom_range(0, 7));
            rst = ($urandom_range(0, 299) == 0);
            apply(o, 8'($urandom), $urandom_range(0, 9) == 0);
            rst = 1'b0;
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
